// File: rtl/button_conditioner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// button_conditioner_if
// Pin-side input and conditioned event outputs of the button conditioner.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int N_CH = 1
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] pressed;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;
  logic            any_press;

  modport master (
    input  btn_in,
    output pressed,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output any_press
  );

  modport slave (
    output btn_in,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  any_press
  );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// button_conditioner
// N-channel push-button synchroniser, debouncer and press/release/long pulses.
// Optional macro: LONG_PRESS_EN (per-channel hold counter driving long_pulse).
// Revision: 1.0
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_CH            = 1,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  button_conditioner_if.master btn
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE_LVL = ACTIVE_LOW;

  logic [N_CH-1:0] pressed_vec;
  logic [N_CH-1:0] press_vec;
  logic [N_CH-1:0] release_vec;
  logic [N_CH-1:0] long_vec;
  logic            any_press_q;
  logic            any_press_d;

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1_q, s1_d, s2_q, s2_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             n_lvl;

    always_comb begin
      s1_d     = btn.btn_in[i];
      s2_d     = s1_q;
      n_lvl    = s2_q ^ ACTIVE_LOW;
      stable_d = stable_q;
      cnt_d    = '0;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      // Any sample matching the stable level restarts the qualification window.
      if (n_lvl != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = n_lvl;
          rise_d   = n_lvl;
          fall_d   = ~n_lvl;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        s1_q     <= IDLE_LVL;
        s2_q     <= IDLE_LVL;
        stable_q <= 1'b0;
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        s1_q     <= s1_d;
        s2_q     <= s2_d;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    assign pressed_vec[i] = stable_q;
    assign press_vec[i]   = rise_q;
    assign release_vec[i] = fall_q;

`ifdef LONG_PRESS_EN
    localparam int                LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] HOLD_MAX  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Saturating at HOLD_MAX keeps long_pulse to one shot per press.
    always_comb begin
      hold_d = '0;
      long_d = 1'b0;
      if (stable_q) begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        long_d = (hold_q == HOLD_LAST);
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    assign long_vec[i] = long_q;
`else
    assign long_vec[i] = 1'b0;
`endif
  end

  always_comb begin
    any_press_d = |press_vec;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign btn.pressed       = pressed_vec;
  assign btn.press_pulse   = press_vec;
  assign btn.release_pulse = release_vec;
  assign btn.long_pulse    = long_vec;
  assign btn.any_press     = any_press_q;
endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Active-low and active-high instances driven with complementary pins and
// compared against a sliding-window reference model plus directed vectors.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_button_conditioner;
  localparam int D = 4;
  localparam int L = 20;
`ifdef LONG_PRESS_EN
  localparam int EXP_LONGS = 1;
`else
  localparam int EXP_LONGS = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pins  = 2'b11;
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;

  always #1 clk = ~clk;

  button_conditioner_if #(.N_CH(2)) if_al ();
  button_conditioner_if #(.N_CH(2)) if_ah ();
  assign if_al.btn_in = pins;
  assign if_ah.btn_in = ~pins;

  button_conditioner #(.N_CH(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L))
    dut_al (.sys_clk(clk), .sys_rst_n(rst_n), .btn(if_al.master));
  button_conditioner #(.N_CH(2), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L))
    dut_ah (.sys_clk(clk), .sys_rst_n(rst_n), .btn(if_ah.master));

  wire [8:0] out_al = {if_al.pressed, if_al.press_pulse, if_al.release_pulse,
                       if_al.long_pulse, if_al.any_press};
  wire [8:0] out_ah = {if_ah.pressed, if_ah.press_pulse, if_ah.release_pulse,
                       if_ah.long_pulse, if_ah.any_press};

  // Reference model: a channel flips when the last D synchronised samples
  // (pin samples delayed two edges) all disagree with its current level.
  bit [1:0] m_pressed, m_press, m_rel, m_long;
  bit       m_any;
  bit       win [2][0:D+1];
  int       cyc;
  int       press_cyc [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < D + 2; j++) win[c][j] = 1'b0;
      press_cyc[c] = 0;
    end
    m_pressed = '0; m_press = '0; m_rel = '0; m_long = '0; m_any = 1'b0; cyc = 0;
  endtask

  task automatic model_step();
    bit flip, old_l, new_l;
    m_any = |m_press;
    for (int c = 0; c < 2; c++) begin
      for (int j = D + 1; j > 0; j--) win[c][j] = win[c][j-1];
      win[c][0] = (pins[c] == 1'b0);
      flip = 1'b1;
      for (int j = 2; j < D + 2; j++) if (win[c][j] == m_pressed[c]) flip = 1'b0;
      old_l = m_pressed[c];
      new_l = flip ? ~old_l : old_l;
      m_press[c] = new_l & ~old_l;
      m_rel[c]   = old_l & ~new_l;
      m_long[c]  = 1'b0;
      if (m_press[c]) press_cyc[c] = cyc;
`ifdef LONG_PRESS_EN
      if (old_l && new_l && (cyc - press_cyc[c] == L)) m_long[c] = 1'b1;
`endif
      m_pressed[c] = new_l;
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_al", 32'(out_al), 32'({m_pressed, m_press, m_rel, m_long, m_any}));
      check("model_ah", 32'(out_ah), 32'({m_pressed, m_press, m_rel, m_long, m_any}));
    end
  end

  typedef struct packed {
    logic [1:0] btn;
    logic [1:0] pressed;
    logic [1:0] press;
    logic [1:0] rel;
    logic       any;
  } vec_t;
  vec_t tbl [15];

  task automatic wait_press(input int ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (if_al.press_pulse[ch]) ok = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   ok;
    int   cnt, pos, rcnt;
    logic [8:0] acc;
    int   run [2];

    // Clean press on ch0 then release; outputs observed after each edge.
    for (int k = 0; k < 15; k++) begin
      tbl[k] = '{btn: (k < 8) ? 2'b10 : 2'b11, pressed: 2'b00, press: 2'b00, rel: 2'b00, any: 1'b0};
      if (k >= 5 && k <= 12) tbl[k].pressed = 2'b01;
    end
    tbl[5].press = 2'b01;
    tbl[6].any   = 1'b1;
    tbl[13].rel  = 2'b01;

    rst_n = 1'b0; pins = 2'b11; chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_al", 32'(out_al), 32'd0);
    check("reset_ah", 32'(out_ah), 32'd0);
    rst_n = 1'b1;
    acc = '0;
    repeat (100) begin @(negedge clk); acc = acc | out_al | out_ah; end
    check("idle_100", 32'(acc), 32'd0);

    for (int k = 0; k < 15; k++) begin
      pins = tbl[k].btn;
      @(negedge clk);
      check($sformatf("tbl_al[%0d]", k), 32'(out_al),
            32'({tbl[k].pressed, tbl[k].press, tbl[k].rel, 2'b00, tbl[k].any}));
      check($sformatf("tbl_ah[%0d]", k), 32'(out_ah),
            32'({tbl[k].pressed, tbl[k].press, tbl[k].rel, 2'b00, tbl[k].any}));
    end
    repeat (6) @(negedge clk);

    // Bounce: never accepted, then a clean hold lands 5 edges after the last edge.
    acc = '0;
    pins = 2'b10; repeat (3) begin @(negedge clk); acc = acc | out_al | out_ah; end
    pins = 2'b11; @(negedge clk); acc = acc | out_al | out_ah;
    pins = 2'b10; repeat (3) begin @(negedge clk); acc = acc | out_al | out_ah; end
    pins = 2'b11; repeat (12) begin @(negedge clk); acc = acc | out_al | out_ah; end
    check("bounce_quiet", 32'(acc), 32'd0);
    pins = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) check("bounce_hold_e4", 32'(out_al), 32'd0);
      if (i == 6) check("bounce_hold_e5", 32'(out_al), 32'({2'b01, 2'b01, 2'b00, 2'b00, 1'b0}));
    end
    pins = 2'b11; repeat (12) @(negedge clk);

    // Long press on ch1.
    pins = 2'b01;
    wait_press(1, ok);
    check("long_press_seen", 32'(ok), 32'd1);
    cnt = 0; pos = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (if_al.long_pulse[1]) begin cnt++; pos = k; end
    end
    check("long_count", 32'(cnt), 32'(EXP_LONGS));
`ifdef LONG_PRESS_EN
    check("long_delay", 32'(pos), 32'(L));
`endif
    pins = 2'b11; cnt = 0; rcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (if_al.long_pulse[1]) cnt++;
      if (if_al.release_pulse[1]) rcnt++;
    end
    check("long_release_cnt", 32'(rcnt), 32'd1);
    check("long_after_release", 32'(cnt), 32'd0);

    // Short press: released before the long-press threshold.
    pins = 2'b01;
    wait_press(1, ok);
    check("short_press_seen", 32'(ok), 32'd1);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (if_al.long_pulse[1]) cnt++; end
    pins = 2'b11;
    repeat (30) begin @(negedge clk); if (if_al.long_pulse[1]) cnt++; end
    check("short_no_long", 32'(cnt), 32'd0);

    // Simultaneous press, then reset while held.
    pins = 2'b00;
    wait_press(0, ok);
    check("sim_press_seen", 32'(ok), 32'd1);
    check("sim_press_al", 32'(if_al.press_pulse), 32'd3);
    check("sim_press_ah", 32'(if_ah.press_pulse), 32'd3);
    @(negedge clk);
    check("sim_any_1", 32'(if_al.any_press), 32'd1);
    @(negedge clk);
    check("sim_any_0", 32'(if_al.any_press), 32'd0);
    @(posedge clk); #0.5;
    rst_n = 1'b0;
    #0.2;
    check("rst_async_al", 32'(out_al), 32'd0);
    check("rst_async_ah", 32'(out_ah), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) check("rst_held_e4", 32'(if_al.press_pulse), 32'd0);
      if (i == 6) check("rst_held_e5", 32'(if_al.press_pulse), 32'd3);
    end
    pins = 2'b11; repeat (10) @(negedge clk);

    // Randomised runs, including long holds and occasional resets.
    run[0] = 1; run[1] = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
        if (run[ch] == 0) begin
          pins[ch] = ~pins[ch];
          run[ch] = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 8);
        end else begin
          run[ch]--;
        end
      end
      if (rst_n && $urandom_range(0, 299) == 0) begin
        #0.5;
        rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised multi-channel push-button input conditioner.
- Sits between the raw board button pins (e.g. `button_in`) and the core/LED logic in `Top`.
- Per channel: 2-FF synchroniser, polarity normalisation, counter-based debounce, registered one-cycle press/release pulses, and an optional long-press pulse.
- Generalises the single active-low button to N channels with configurable polarity and debounce time.

Parameters:
- N_CH, 1, number of independent button channels.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 270000, cycles the synchronised input must differ from the stable state before it is accepted (10 ms at 27 MHz); legal range >= 1.
- LONG_CYCLES, 27000000, cycles of continuous debounced press before `long_pulse` fires (1 s at 27 MHz); legal range >= 1; used only with LONG_PRESS_EN.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- btn_in  input  N_CH  raw asynchronous button pins.
- pressed  output  N_CH  debounced level, 1 = pressed, independent of ACTIVE_LOW.
- press_pulse  output  N_CH  one-cycle pulse on accepted press.
- release_pulse  output  N_CH  one-cycle pulse on accepted release.
- long_pulse  output  N_CH  one-cycle pulse on long press; constant 0 without LONG_PRESS_EN.
- any_press  output  1  registered OR of `press_pulse` across channels, one cycle after it.

Behaviour:
- Reset (async assert, sync-free deassert use):
  - synchroniser flops load the released pin level: 1 if ACTIVE_LOW, else 0;
  - stable state 0; all counters 0;
  - all outputs 0.
- Synchroniser: `s1 <= pin`; `s2 <= s1`. Normalised `n = ACTIVE_LOW ? ~s2 : s2`.
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES+1)`, one per channel, channels fully independent.
  - `n == stable`: counter <= 0.
  - `n != stable`, counter < DEBOUNCE_CYCLES-1: counter increments.
  - `n != stable`, counter == DEBOUNCE_CYCLES-1: `stable <= n`, counter <= 0.
- Latency: a clean pin transition first sampled at edge E0 changes `pressed` at edge E0+DEBOUNCE_CYCLES+1.
- Glitch rejection: any return to the stable level before acceptance clears the counter. A bounce of DEBOUNCE_CYCLES-1 or fewer synchronised cycles never reaches the outputs.
- Pulses: registered.
  - `press_pulse` is high exactly in the first cycle `pressed` is 1.
  - `release_pulse` is high exactly in the first cycle `pressed` is 0 after being 1.
  - The two are never high together on a channel.
  - Back-to-back accepted transitions are at least DEBOUNCE_CYCLES cycles apart, so pulses never merge.
- `pressed` is a direct register, not combinational from the pin.
- Reset mid-debounce or mid-press: counters and state cleared; no pulse is emitted on reset entry or exit.
- A button held through reset deassertion is seen as a new press: `press_pulse` follows after the normal latency.
- Simultaneous events on multiple channels: each channel pulses in the same cycle; `any_press` is a single one-cycle pulse.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined: each channel has a hold counter, width `$clog2(LONG_CYCLES+1)`.
  - Counter clears while `pressed` = 0 and increments while `pressed` = 1.
  - When it reaches LONG_CYCLES, `long_pulse` is high for one cycle, i.e. LONG_CYCLES cycles after `press_pulse`.
  - The counter then saturates: no further `long_pulse` until release and a new press.
  - A release before LONG_CYCLES produces no `long_pulse`.
- Undefined: no hold-counter logic is synthesised; `long_pulse` is tied to 0.

Test Plan:
Bench clock 2 ns period. Unless stated: N_CH=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, LONG_PRESS_EN defined.
- Reset: hold sys_rst_n=0 10 ns with btn_in=2'b11 -> all outputs 0; release reset with pins idle -> outputs stay 0 for 100 cycles.
- Clean press: ch0 1->0 sampled at edge E0 and held -> `pressed[0]` rises at E0+5; `press_pulse[0]` high for exactly one cycle there; `any_press` high one cycle later; ch1 unaffected.
- Bounce: ch0 toggles low 3 cycles, high 1, low 3, then back high -> no change on any output. Then hold low -> accepted 5 edges after the last transition.
- Release and long press: hold ch1 low 30 cycles after acceptance -> `long_pulse[1]` fires once, 20 cycles after `press_pulse[1]`. Release -> `release_pulse[1]` once, with no second `long_pulse`. A press held only 10 cycles -> no `long_pulse`.
- Simultaneous and reset mid-press: press both channels on the same edge -> both `press_pulse` bits in the same cycle, a single `any_press` pulse. Assert reset while both pressed -> outputs 0 immediately, no `release_pulse`. Deassert with buttons held -> `press_pulse` 5 edges later.
- Macro off, and ACTIVE_LOW=0: rerun the long-press case without LONG_PRESS_EN -> `long_pulse` stays 0. Rerun the clean-press case with ACTIVE_LOW=0 and inverted stimulus -> identical output timing.
